// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised Mealy serial-pattern detector.
//
// Shifts qualified serial bits into a history register and flags `out` in the
// same cycle the final bit of the run-time-loaded pattern is presented.
// Overlapping or non-overlapping detection is selected per bit. A saturating
// counter tallies matches.
//
// Optional build macro: SEQ_DETECT_MASK_EN
//   Adds pat_mask_in and a mask register (a 0 marks a don't-care position).
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid/in  qualified serial data bit
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   pat_load     load pat_in (and pat_mask_in) and flush the history
//   pat_in       new pattern value; the first-received bit is the MSB
//   cnt_clr      clear the match counter (wins over a simultaneous match)
//   out          combinational match flag
//   match_cnt    saturating match count
//   fill         number of valid history bits, 0..PAT_W-1
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1101,
  parameter int               CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in,
  input  logic                     overlap,
  input  logic                     pat_load,
  input  logic [PAT_W-1:0]         pat_in,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [PAT_W-1:0]         pat_mask_in,
`endif
  input  logic                     cnt_clr,
  output logic                     out,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [$clog2(PAT_W)-1:0] fill
);

  localparam int             FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [PAT_W-1:0] cand;
  logic             hit;
`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_W-1:0] mask_q, mask_d;
`endif

  // Match decode: the candidate is the history with the incoming bit appended.
  always_comb begin
    cand = {hist_q, in};
`ifdef SEQ_DETECT_MASK_EN
    hit  = ((cand ^ pat_q) & mask_q) == '0;
`else
    hit  = (cand == pat_q);
`endif
    out  = in_valid & ~pat_load & (fill_q == FILL_MAX) & hit;
  end

  always_comb begin
    pat_d       = pat_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_cnt_d = match_cnt_q;
`ifdef SEQ_DETECT_MASK_EN
    mask_d      = mask_q;
`endif
    // A pattern load drops any concurrent bit and restarts the history.
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
`ifdef SEQ_DETECT_MASK_EN
      mask_d = pat_mask_in;
`endif
    end else if (in_valid) begin
      hist_d = cand[PAT_W-2:0];
      // Non-overlapping: discard the matched window so none of it is reused.
      if (out && !overlap)
        fill_d = '0;
      else if (fill_q != FILL_MAX)
        fill_d = fill_q + FW'(1);
    end
    if (cnt_clr)
      match_cnt_d = '0;
    else if (out && (match_cnt_q != '1))
      match_cnt_d = match_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q       <= PAT_RST;
      hist_q      <= '0;
      fill_q      <= '0;
      match_cnt_q <= '0;
`ifdef SEQ_DETECT_MASK_EN
      mask_q      <= '1;
`endif
    end else begin
      pat_q       <= pat_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_cnt_q <= match_cnt_d;
`ifdef SEQ_DETECT_MASK_EN
      mask_q      <= mask_d;
`endif
    end
  end

  assign match_cnt = match_cnt_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, in_valid, in, overlap, pat_load, cnt_clr;
  logic [PAT_W-1:0] pat_in, pat_mask_in;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0]       fill;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(PAT_W), .PAT_RST(4'b1101), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DETECT_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .cnt_clr(cnt_clr), .out(out), .match_cnt(match_cnt), .fill(fill)
  );

  typedef struct {
    logic       o;
    logic [1:0] f;
    logic [7:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic cur_ov = 1'b1;

  // reference model: history kept as a bit queue, oldest first
  int         m_hist[$];
  logic [3:0] m_pat  = 4'b1101;
  logic [3:0] m_mask = 4'b1111;
  int         m_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input logic b, input logic ov, input logic pl,
                      input logic [3:0] pi, input logic [3:0] mi,
                      input logic cc, input logic rs);
    exp_t       e;
    logic [3:0] cand;
    logic       obs_out;
    in_valid = iv; in = b; overlap = ov; pat_load = pl;
    pat_in = pi; pat_mask_in = mi; cnt_clr = cc; rst = rs;
    cand = '0;
    foreach (m_hist[i]) cand = {cand[2:0], m_hist[i][0]};
    cand = {cand[2:0], b};
    e.o = iv && !pl && (m_hist.size() == PAT_W-1) && (((cand ^ m_pat) & m_mask) == 4'b0);
    if (rs) begin
      m_hist.delete(); m_pat = 4'b1101; m_mask = 4'b1111; m_cnt = 0;
    end else begin
      if (pl) begin
        m_pat = pi;
`ifdef SEQ_DETECT_MASK_EN
        m_mask = mi;
`endif
        m_hist.delete();
      end else if (iv) begin
        if (e.o && !ov) m_hist.delete();
        else begin
          m_hist.push_back(int'(b));
          if (m_hist.size() > PAT_W-1) void'(m_hist.pop_front());
        end
      end
      if (cc) m_cnt = 0;
      else if (e.o && m_cnt < 255) m_cnt++;
    end
    e.f = 2'(m_hist.size());
    e.c = 8'(m_cnt);
    sb.push_back(e);
    #1 obs_out = out;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("out", obs_out, e.o);
    chk("fill", fill, e.f);
    chk("match_cnt", match_cnt, e.c);
    @(negedge clk);
  endtask

  task automatic feed(input logic b);
    step(1'b1, b, cur_ov, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, cur_ov, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    step(1'b1, 1'b1, cur_ov, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1);
  endtask

  task automatic load(input logic [3:0] p, input logic [3:0] m);
    step(1'b0, 1'b0, cur_ov, 1'b1, p, m, 1'b0, 1'b0);
  endtask

  task automatic feed_stream(input logic [11:0] s, input int n);
    logic [11:0] v;
    v = s;
    for (int i = n-1; i >= 0; i--) feed(v[i]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in = 1'b0; overlap = 1'b1; pat_load = 1'b0;
    pat_in = '0; pat_mask_in = '1; cnt_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    do_rst();

    // overlapping: 1,1,0,1,1,0,1,1,1,0,1,1 -> pulses on bits 4, 7, 11
    cur_ov = 1'b1;
    feed_stream(12'b1101_1011_1011, 12);
    chk("t1_cnt", match_cnt, 3);

    // non-overlapping on the same stream -> bits 4 and 11 only
    do_rst();
    cur_ov = 1'b0;
    feed_stream(12'b1101_1011_1011, 12);
    chk("t2_cnt", match_cnt, 2);

    // gaps in in_valid are transparent
    do_rst();
    cur_ov = 1'b1;
    feed(1'b1); feed(1'b1); feed(1'b0);
    idle(); idle(); idle();
    feed(1'b1);
    chk("gap_cnt", match_cnt, 1);

    // load wins over a concurrent valid bit at fill=3
    do_rst();
    feed(1'b1); feed(1'b1); feed(1'b0);
    chk("pre_load_fill", fill, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 4'hF, 1'b0, 1'b0);
    chk("load_fill", fill, 0);
    feed_stream(12'b0110, 4);
    chk("load_cnt", match_cnt, 1);
    load(4'b1101, 4'hF);

    // reset mid-pattern discards history
    feed(1'b1); feed(1'b1);
    do_rst();
    feed(1'b0); feed(1'b1);
    chk("rst_mid_cnt", match_cnt, 0);

    // saturation at 255, then cnt_clr wins over a match
    do_rst();
    cur_ov = 1'b1;
    feed(1'b1);
    for (int i = 0; i < 260; i++) begin
      feed(1'b1); feed(1'b0); feed(1'b1);
    end
    chk("sat_cnt", match_cnt, 255);
    feed(1'b1); feed(1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0);
    chk("clr_cnt", match_cnt, 0);

    // overlap change mid-stream takes effect on the next consumed bit
    do_rst();
    cur_ov = 1'b1;
    feed_stream(12'b1101, 4);
    cur_ov = 1'b0;
    feed_stream(12'b101, 3);
    feed_stream(12'b101, 3);
    chk("ovchg_cnt", match_cnt, 2);

`ifdef SEQ_DETECT_MASK_EN
    do_rst();
    cur_ov = 1'b0;
    load(4'b1101, 4'b1011);
    feed_stream(12'b1101, 4);
    feed_stream(12'b1001, 4);
    feed_stream(12'b0101, 4);
    chk("mask_cnt", match_cnt, 2);
`endif

    // random traffic against the model
    do_rst();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 40) == 0, 4'($urandom), 4'($urandom),
           $urandom_range(0, 30) == 0, $urandom_range(0, 60) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
